// File: rtl/sigmoid_arb_pkg.sv
// rtl/sigmoid_arb_pkg.sv - shared types and helpers for the sigmoid arbiter
//
// Purpose: data/state typedefs and the tag-width helper used by sigmoid_arbiter.
// Ports: none (package).
package sigmoid_arb_pkg;

  localparam int SIG_DW_DEFAULT = 32;

  typedef logic signed [SIG_DW_DEFAULT-1:0] sig_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Width of a requester ID; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sigmoid_tag_fifo.sv
// rtl/sigmoid_tag_fifo.sv - in-flight requester tag FIFO
//
// Purpose: synchronous FIFO of requester tags in issue order.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_tag (accepted when not full, or when popping in the same cycle)
//   push_tag     tag to write
//   pop          remove the head entry (ignored when empty)
//   pop_tag      current head entry
//   full, empty  occupancy flags
module sigmoid_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_tag,
  input  logic         pop,
  output logic [W-1:0] pop_tag,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_tag = mem_q[rd_q];

  // A pop in the same cycle frees the head slot, so a full FIFO still takes the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_tag;
      wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// rtl/sigmoid_arbiter.sv - round-robin arbiter sharing one pipelined sigmoid core
//
// Purpose: grants NREQ lanes round-robin, paces issue to ISSUE_GAP cycles, tracks
// in-flight lane tags and routes each core result back to its lane in issue order.
// Optional build macro: SIGMOID_ARB_STATS_EN adds stat_grants / stat_stall counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_data    lane operands (lane i at [i*DW +: DW])
//   req_ready             one-hot grant (combinational on req_valid)
//   rsp_valid/rsp_data    one-hot result strobe and shared result data
//   sig_ena/sig_in        issue pulse and operand to the core
//   sig_valid/sig_out     core result strobe and data
//   busy                  op in flight or arbiter not idle
//   err_orphan            sticky: core result with nothing in flight
//   stat_grants/stat_stall (stats build only) saturating counters
module sigmoid_arbiter
  import sigmoid_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = 32,
  parameter int ISSUE_GAP    = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               sig_ena,
  output logic [DW-1:0]      sig_in,
  input  logic               sig_valid,
  input  logic [DW-1:0]      sig_out,
  output logic               busy,
  output logic               err_orphan
`ifdef SIGMOID_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  localparam int TW = tag_w(NREQ);
  localparam int GW = (ISSUE_GAP <= 2) ? 1 : $clog2(ISSUE_GAP);

  arb_state_t       state_q, state_d;
  logic [TW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sig_ena_q, sig_ena_d;
  logic [DW-1:0]    sig_in_q, sig_in_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic             fifo_full, fifo_empty, pop, can_issue, transfer;
  logic [TW-1:0]    head_tag;
  logic             gnt_found;
  logic [TW-1:0]    gnt_idx;
  logic [TW:0]      cand;
  logic [DW-1:0]    gnt_data;

  // First valid lane at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (TW+1)'(k);
      if (cand >= (TW+1)'(NREQ)) cand = cand - (TW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[TW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[TW-1:0];
      end
    end
  end

  assign pop       = sig_valid & ~fifo_empty;
  assign can_issue = (state_q == ISSUE) & (~fifo_full | pop);
  assign transfer  = can_issue & gnt_found;
  assign req_ready = transfer ? (NREQ'(1) << gnt_idx) : '0;
  assign gnt_data  = req_data[gnt_idx*DW +: DW];

  sigmoid_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (transfer),
    .push_tag (gnt_idx),
    .pop      (pop),
    .pop_tag  (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    ptr_d       = ptr_q;
    sig_ena_d   = transfer;
    sig_in_d    = transfer ? gnt_data : sig_in_q;
    rsp_valid_d = pop ? (NREQ'(1) << head_tag) : '0;
    rsp_data_d  = pop ? sig_out : rsp_data_q;
    err_d       = err_q | (sig_valid & fifo_empty);

    if (transfer) begin
      ptr_d = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (transfer) begin
          if (ISSUE_GAP > 1) begin
            state_d = GAP;
            // GAP lasts ISSUE_GAP-1 cycles so issue pulses land exactly ISSUE_GAP apart.
            gap_d   = GW'(ISSUE_GAP - 2);
          end
        end else if (!(|req_valid) && fifo_empty) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = ((|req_valid) || !fifo_empty) ? ISSUE : IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gap_q       <= '0;
      sig_ena_q   <= 1'b0;
      sig_in_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      sig_ena_q   <= sig_ena_d;
      sig_in_q    <= sig_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign sig_ena    = sig_ena_q;
  assign sig_in     = sig_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;

`ifdef SIGMOID_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] grant_cnt_d [NREQ];
  logic [15:0] stall_q, stall_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_d     = stall_q;
    if (transfer && grant_cnt_q[gnt_idx] != 16'hFFFF) begin
      grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 16'd1;
    end
    if ((|req_valid) && fifo_full && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_q     <= stall_d;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    assign stat_grants[i*16 +: 16] = grant_cnt_q[i];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb/tb_sigmoid_arbiter.sv - directed self-checking bench for sigmoid_arbiter
module tb_sigmoid_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              sig_ena;
  logic [DW-1:0]     sig_in;
  logic              sig_valid;
  logic [DW-1:0]     sig_out;
  logic              busy;
  logic              err_orphan;
`ifdef SIGMOID_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  sigmoid_arbiter #(
    .NREQ(NREQ), .DW(DW), .ISSUE_GAP(2), .MAX_INFLIGHT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .sig_ena    (sig_ena),
    .sig_in     (sig_in),
    .sig_valid  (sig_valid),
    .sig_out    (sig_out),
    .busy       (busy),
    .err_orphan (err_orphan)
`ifdef SIGMOID_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 3;
  logic inject_req = 1'b0;

  // Hand-computed results of the core model for operands 100,200,300,400.
  logic [31:0] exp_rsp [4] = '{32'd1025, 32'd1050, 32'd1075, 32'd1100};

  logic        slot_v [0:63];
  logic [31:0] slot_d [0:63];

  int          gr_lane[$];
  int          gr_cyc[$];
  int          ena_cyc[$];
  int          sv_cyc[$];
  logic [3:0]  rsp_vec[$];
  logic [31:0] rsp_dat[$];
  int          rsp_cyc[$];

  function automatic logic [31:0] sig_model(input logic [31:0] x);
    return ($signed(x) >>> 2) + 32'sd1000;
  endfunction

  always @(posedge clk) cyc++;

  // Sigmoid core model: fixed latency `lat` from sig_ena to sig_valid.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin slot_v[i] = 1'b0; slot_d[i] = '0; end
      sig_valid  = 1'b0;
      sig_out    = '0;
      inject_req = 1'b0;
    end else begin
      for (int i = 0; i < 63; i++) begin slot_v[i] = slot_v[i+1]; slot_d[i] = slot_d[i+1]; end
      slot_v[63] = 1'b0;
      if (sig_ena) begin
        slot_v[lat] = 1'b1;
        slot_d[lat] = sig_model(sig_in);
      end
      sig_valid  = slot_v[0] | inject_req;
      sig_out    = slot_v[0] ? slot_d[0] : 32'h0;
      inject_req = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        for (int l = 0; l < NREQ; l++)
          if (req_valid[l] && req_ready[l]) begin gr_lane.push_back(l); gr_cyc.push_back(cyc); end
      end
      if (sig_ena) ena_cyc.push_back(cyc);
      if (sig_valid) sv_cyc.push_back(cyc);
      if (rsp_valid != '0) begin
        rsp_vec.push_back(rsp_valid); rsp_dat.push_back(rsp_data); rsp_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    gr_lane.delete(); gr_cyc.delete(); ena_cyc.delete(); sv_cyc.delete();
    rsp_vec.delete(); rsp_dat.delete(); rsp_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_lanes(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic wait_transfers(input int n, input int max_cyc);
    int t = 0;
    while (gr_lane.size() < n && t < max_cyc) begin tick(); t++; end
    checks++;
    if (gr_lane.size() < n) begin
      failures++;
      $display("FAIL wait_transfers timeout got=%0d need=%0d", gr_lane.size(), n);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    while (busy !== 1'b0 && t < max_cyc) begin tick(); t++; end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    set_lanes(32'd1, 32'd2, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL reset_rsp_valid got=%h exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (sig_ena !== 1'b0) begin failures++; $display("FAIL reset_sig_ena got=%b exp=0", sig_ena); end
    checks++; if (sig_in !== 32'h0) begin failures++; $display("FAIL reset_sig_in got=%h exp=0", sig_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_single_lane();
    apply_reset();
    lat = 3;
    set_lanes(32'd0, -32'sd1972, 32'd0, 32'd0);
    req_valid = 4'b0010;
    wait_transfers(1, 20);
    req_valid = '0;
    wait_idle(60);
    checks++;
    if (gr_lane.size() != 1 || gr_lane[0] != 1) begin
      failures++; $display("FAIL single_grant count=%0d lane=%0d exp count=1 lane=1",
                           gr_lane.size(), gr_lane.size() > 0 ? gr_lane[0] : -1);
    end
    checks++;
    if (ena_cyc.size() != 1 || gr_cyc.size() < 1 || ena_cyc[0] != gr_cyc[0] + 1) begin
      failures++; $display("FAIL single_ena_latency ena_count=%0d exp 1 pulse one cycle after grant", ena_cyc.size());
    end
    checks++;
    if (rsp_vec.size() != 1 || rsp_vec[0] !== 4'b0010) begin
      failures++; $display("FAIL single_rsp_valid count=%0d exp one 0010", rsp_vec.size());
    end
    checks++;
    if (rsp_dat.size() != 1 || rsp_dat[0] !== 32'd507) begin
      failures++; $display("FAIL single_rsp_data got=%0d exp=507", rsp_dat.size() > 0 ? $signed(rsp_dat[0]) : -1);
    end
    checks++;
    if (rsp_cyc.size() != 1 || sv_cyc.size() != 1 || rsp_cyc[0] != sv_cyc[0] + 1) begin
      failures++; $display("FAIL single_rsp_latency rsp_count=%0d sv_count=%0d exp rsp 1 cycle after sig_valid",
                           rsp_cyc.size(), sv_cyc.size());
    end
  endtask

  task automatic test_all_lanes();
    apply_reset();
    lat = 3;
    set_lanes(32'd100, 32'd200, 32'd300, 32'd400);
    req_valid = 4'hF;
    wait_transfers(8, 100);
    req_valid = '0;
    wait_idle(60);
    checks++;
    if (gr_lane.size() != 8) begin failures++; $display("FAIL all_grant_count got=%0d exp=8", gr_lane.size()); end
    for (int i = 0; i < 8 && i < gr_lane.size(); i++) begin
      checks++;
      if (gr_lane[i] != i % 4) begin failures++; $display("FAIL all_grant_order[%0d] got=%0d exp=%0d", i, gr_lane[i], i % 4); end
    end
    for (int i = 1; i < ena_cyc.size(); i++) begin
      checks++;
      if (ena_cyc[i] - ena_cyc[i-1] != 2) begin
        failures++; $display("FAIL all_ena_spacing[%0d] got=%0d exp=2", i, ena_cyc[i] - ena_cyc[i-1]);
      end
    end
    checks++;
    if (rsp_vec.size() != 8) begin failures++; $display("FAIL all_rsp_count got=%0d exp=8", rsp_vec.size()); end
    for (int i = 0; i < 8 && i < rsp_vec.size(); i++) begin
      checks++;
      if (rsp_vec[i] !== (4'b0001 << (i % 4)) || rsp_dat[i] !== exp_rsp[i % 4]) begin
        failures++; $display("FAIL all_rsp[%0d] got vec=%b data=%0d exp vec=%b data=%0d",
                             i, rsp_vec[i], rsp_dat[i], 4'b0001 << (i % 4), exp_rsp[i % 4]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    lat = 20;
    set_lanes(32'd100, 32'd200, 32'd300, 32'd400);
    req_valid = 4'hF;
    wait_transfers(4, 50);
    repeat (6) tick();
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL stall_req_ready got=%b exp=0000", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
    checks++; if (gr_lane.size() != 4) begin failures++; $display("FAIL stall_grants_held got=%0d exp=4", gr_lane.size()); end
    wait_transfers(8, 300);
    req_valid = '0;
    wait_idle(300);
    for (int k = 4; k < 8 && k < gr_cyc.size() && k - 4 < sv_cyc.size(); k++) begin
      checks++;
      if (gr_cyc[k] != sv_cyc[k-4]) begin
        failures++; $display("FAIL stall_grant_on_pop[%0d] grant_cyc=%0d exp=%0d", k, gr_cyc[k], sv_cyc[k-4]);
      end
    end
    checks++;
    if (rsp_vec.size() != 8) begin failures++; $display("FAIL stall_rsp_count got=%0d exp=8", rsp_vec.size()); end
    for (int i = 0; i < 8 && i < rsp_vec.size(); i++) begin
      checks++;
      if (rsp_vec[i] !== (4'b0001 << (i % 4)) || rsp_dat[i] !== exp_rsp[i % 4]) begin
        failures++; $display("FAIL stall_rsp[%0d] got vec=%b data=%0d exp vec=%b data=%0d",
                             i, rsp_vec[i], rsp_dat[i], 4'b0001 << (i % 4), exp_rsp[i % 4]);
      end
    end
  endtask

  task automatic test_orphan();
    apply_reset();
    lat = 3;
    @(negedge clk);
    inject_req = 1'b1;
    repeat (4) tick();
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", err_orphan); end
    checks++; if (rsp_vec.size() != 0) begin failures++; $display("FAIL orphan_no_rsp got=%0d exp=0", rsp_vec.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL orphan_busy got=%b exp=0", busy); end
    set_lanes(32'd0, 32'd0, 32'd0, 32'd400);
    req_valid = 4'b1000;
    wait_transfers(1, 20);
    req_valid = '0;
    wait_idle(60);
    checks++;
    if (rsp_vec.size() != 1 || rsp_vec[0] !== 4'b1000 || rsp_dat[0] !== 32'd1100) begin
      failures++; $display("FAIL orphan_followup_rsp count=%0d exp one 1000 data 1100", rsp_vec.size());
    end
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat = 20;
    set_lanes(32'd100, 32'd200, 32'd300, 32'd400);
    req_valid = 4'hF;
    wait_transfers(3, 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL midrst_req_ready got=%b exp=0000", req_ready); end
    checks++; if (sig_ena !== 1'b0 || rsp_valid !== 4'h0) begin
      failures++; $display("FAIL midrst_outputs sig_ena=%b rsp_valid=%b exp 0", sig_ena, rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_transfers(1, 20);
    req_valid = '0;
    checks++;
    if (gr_lane.size() < 1 || gr_lane[0] != 0) begin
      failures++; $display("FAIL midrst_ptr_restart lane=%0d exp=0", gr_lane.size() > 0 ? gr_lane[0] : -1);
    end
    wait_idle(100);
    checks++;
    if (rsp_vec.size() != 1 || rsp_vec[0] !== 4'b0001 || rsp_dat[0] !== 32'd1025) begin
      failures++; $display("FAIL midrst_rsp count=%0d exp one 0001 data 1025", rsp_vec.size());
    end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err_orphan); end
  endtask

`ifdef SIGMOID_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    lat = 3;
    set_lanes(32'd0, 32'd0, 32'd300, 32'd0);
    req_valid = 4'b0100;
    wait_transfers(10, 100);
    req_valid = '0;
    wait_idle(60);
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (stat_grants[l*16 +: 16] !== ((l == 2) ? 16'd10 : 16'd0)) begin
        failures++; $display("FAIL stat_grants[%0d] got=%0d exp=%0d", l, stat_grants[l*16 +: 16], (l == 2) ? 10 : 0);
      end
    end
    checks++; if (stat_stall !== 16'd0) begin failures++; $display("FAIL stat_stall got=%0d exp=0", stat_stall); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_stall();
    test_orphan();
    test_reset_mid();
`ifdef SIGMOID_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
